quantize_stream: RTL

//  Streaming, pipelined JPEG quantizer. Successor to the 64-wide combinational quantizer.

---
 rtl/quantize_stream.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/quantize_stream.sv
// Streaming JPEG quantizer: LANES Q16.16 coefficients per beat through a two-stage pipeline,
// scaled by a per-block luma/chroma inverse table, rounded half away from zero and saturated.
module quantize_stream #(
  parameter int LANES = 8,
  parameter int OUT_W = 12
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   mode_luma,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [32*LANES-1:0]    in_data,
  input  logic                   in_last,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [OUT_W*LANES-1:0] out_data,
  output logic                   out_last,
  output logic                   out_luma,
  output logic                   err_framing
);

  localparam int BEATS = 64 / LANES;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);
  localparam logic signed [32:0] MAX_Q = (33'sd1 <<< (OUT_W - 1)) - 33'sd1;
  localparam logic signed [32:0] MIN_Q = -(33'sd1 <<< (OUT_W - 1));

  // Standard JPEG quantisation steps in natural order, entry 0 in the top byte.
  localparam logic [64*8-1:0] LUMA_Q = {
    8'd16, 8'd11, 8'd10, 8'd16, 8'd24,  8'd40,  8'd51,  8'd61,
    8'd12, 8'd12, 8'd14, 8'd19, 8'd26,  8'd58,  8'd60,  8'd55,
    8'd14, 8'd13, 8'd16, 8'd24, 8'd40,  8'd57,  8'd69,  8'd56,
    8'd14, 8'd17, 8'd22, 8'd29, 8'd51,  8'd87,  8'd80,  8'd62,
    8'd18, 8'd22, 8'd37, 8'd56, 8'd68,  8'd109, 8'd103, 8'd77,
    8'd24, 8'd35, 8'd55, 8'd64, 8'd81,  8'd104, 8'd113, 8'd92,
    8'd49, 8'd64, 8'd78, 8'd87, 8'd103, 8'd121, 8'd120, 8'd101,
    8'd72, 8'd92, 8'd95, 8'd98, 8'd112, 8'd100, 8'd103, 8'd99
  };
  localparam logic [64*8-1:0] CHROMA_Q = {
    8'd17, 8'd18, 8'd24, 8'd47, 8'd99, 8'd99, 8'd99, 8'd99,
    8'd18, 8'd21, 8'd26, 8'd66, 8'd99, 8'd99, 8'd99, 8'd99,
    8'd24, 8'd26, 8'd56, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99,
    8'd47, 8'd66, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99,
    8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99,
    8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99,
    8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99,
    8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99
  };

  // Elaboration-time Q16.16 reciprocal of each step, rounded to nearest.
  function automatic logic [64*32-1:0] build_inv(input logic [64*8-1:0] q);
    logic [64*32-1:0] t;
    logic [31:0]      d;
    t = '0;
    for (int k = 0; k < 64; k++) begin
      d = {24'd0, q[(63-k)*8 +: 8]};
      t[(63-k)*32 +: 32] = (32'd65536 + (d >> 1)) / d;
    end
    return t;
  endfunction

  localparam logic [64*32-1:0] LUMA_INV   = build_inv(LUMA_Q);
  localparam logic [64*32-1:0] CHROMA_INV = build_inv(CHROMA_Q);

  function automatic logic [31:0] inv_lookup(input logic luma, input int idx);
    return luma ? LUMA_INV[(63-idx)*32 +: 32] : CHROMA_INV[(63-idx)*32 +: 32];
  endfunction

  // Q32.32 product to integer: bias toward zero on negatives so ties round away from zero.
  function automatic logic [OUT_W-1:0] round_sat(input logic signed [63:0] p);
    logic signed [64:0] s;
    logic signed [32:0] q;
    s = (p >= 0) ? (65'(p) + 65'sd2147483648) : (65'(p) + 65'sd2147483647);
    q = 33'(s >>> 32);
    if (q > MAX_Q) return MAX_Q[OUT_W-1:0];
    if (q < MIN_Q) return MIN_Q[OUT_W-1:0];
    return q[OUT_W-1:0];
  endfunction

  logic                   adv, accept, cur_luma, beat_last;
  logic [BW-1:0]          beat_cnt;
  logic                   blk_luma;
  logic signed [63:0]     prod   [LANES];
  logic signed [63:0]     s1_prod[LANES];
  logic                   s1_valid, s1_last, s1_luma;
  logic [OUT_W*LANES-1:0] out_next;

  assign adv       = !out_valid || out_ready;
  assign in_ready  = adv;
  assign accept    = in_valid && adv;
  assign beat_last = (beat_cnt == LAST_BEAT);
  assign cur_luma  = (beat_cnt == '0) ? mode_luma : blk_luma;

  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      prod[i] = 64'($signed(in_data[32*i +: 32])) *
                64'($signed({1'b0, inv_lookup(cur_luma, int'(beat_cnt) * LANES + i)}));
    end
  end

  always_comb begin
    out_next = '0;
    for (int i = 0; i < LANES; i++) begin
      out_next[OUT_W*i +: OUT_W] = round_sat(s1_prod[i]);
    end
  end

  // Beat tracking runs on every accept; both pipeline stages move together only when adv is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt    <= '0;
      blk_luma    <= 1'b0;
      err_framing <= 1'b0;
      s1_valid    <= 1'b0;
      s1_last     <= 1'b0;
      s1_luma     <= 1'b0;
      for (int i = 0; i < LANES; i++) s1_prod[i] <= '0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_last    <= 1'b0;
      out_luma    <= 1'b0;
    end else begin
      if (accept) begin
        beat_cnt <= beat_last ? '0 : beat_cnt + 1'b1;
        if (beat_cnt == '0) blk_luma <= mode_luma;
        if (in_last != beat_last) err_framing <= 1'b1;
      end
      if (adv) begin
        s1_valid <= accept;
        if (accept) begin
          s1_prod <= prod;
          s1_last <= beat_last;
          s1_luma <= cur_luma;
        end
        out_valid <= s1_valid;
        if (s1_valid) begin
          out_data <= out_next;
          out_last <= s1_last;
          out_luma <= s1_luma;
        end
      end
    end
  end

endmodule
